// File: rtl/la_pkg.sv
// Shared types and defaults for the logic-analyzer trigger/scan stage.
package la_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_SCAN,
        S_READY
    } la_state_t;

    localparam int LA_ADDR_W       = 17;
    localparam int LA_IDLE_TIMEOUT = 50000;

    typedef logic [7:0] sample_t;

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module la_sample_ram
    import la_pkg::*;
#(
    parameter int ADDR_W = LA_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  sample_t           i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output sample_t           o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    sample_t r_mem [DEPTH];
    sample_t r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/la_trigger_scan.sv
// Sample capture, end-of-capture detection, trigger edge scan and
// trigger-relative sample readback for the logic analyzer.
module la_trigger_scan
    import la_pkg::*;
#(
    parameter int ADDR_W       = LA_ADDR_W,
    parameter int IDLE_TIMEOUT = LA_IDLE_TIMEOUT
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic [2:0]        trig_ch,
    input  logic              trig_edge,
    output logic              cap_done,
    output logic              scan_busy,
    output logic              ready,
    output logic              trig_found,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W:0]   sample_cnt,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_offset,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              rd_oob
);

    localparam int CW = ADDR_W + 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [IW-1:0]     IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    la_state_t         r_state;
    la_state_t         w_next;
    logic [IW-1:0]     r_idle;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_cyc;
    logic [CW-1:0]     r_rd_sum;
    logic [ADDR_W-1:0] r_trig_addr;
    logic              r_trig_found;
    logic              r_cap_done;
    logic [2:0]        r_ch;
    logic              r_edge;
    logic              r_prev;
    logic              r_rd_v1;
    logic              r_rd_v2;
    logic              r_rd_oob;

    logic [ADDR_W-1:0] w_ram_raddr;
    sample_t           w_ram_q;
    logic [CW-1:0]     w_wr_cnt;
    logic              w_full;
    logic              w_timeout;
    logic              w_cur;
    logic              w_match;
    logic              w_scan_end;
    logic              w_enter_scan;
    logic              w_abort;

    assign w_wr_cnt  = {1'b0, wr_addr} + CW'(1);
    assign w_full    = wr_en && (wr_addr == ADDR_MAX);
    assign w_timeout = (r_idle == IDLE_LAST) && !wr_en;
    assign w_abort   = wr_en && (r_state == S_SCAN || r_state == S_READY);

    // Scan cycle k carries sample k-1 out of the RAM; r_prev holds sample k-2.
    assign w_cur      = w_ram_q[r_ch];
    assign w_match    = (r_cyc >= CW'(2)) && (r_cyc <= r_cnt) &&
                        (r_edge ? (!r_prev && w_cur) : (r_prev && !w_cur));
    assign w_scan_end = w_match || (r_cyc == r_cnt + CW'(1));

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (wr_en) w_next = w_full ? S_SCAN : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_full || w_timeout) w_next = S_SCAN;
            end
            S_SCAN: begin
                if (wr_en)           w_next = S_CAPTURE;
                else if (w_scan_end) w_next = S_READY;
            end
            S_READY: begin
                if (wr_en) w_next = S_CAPTURE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_scan = (w_next == S_SCAN) && (r_state != S_SCAN);

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_idle       <= '0;
            r_cnt        <= '0;
            r_cyc        <= '0;
            r_trig_addr  <= '0;
            r_trig_found <= 1'b0;
            r_cap_done   <= 1'b0;
            r_ch         <= '0;
            r_edge       <= 1'b0;
            r_prev       <= 1'b0;
        end else begin
            r_cap_done <= w_enter_scan;
            r_prev     <= w_cur;
            r_cyc      <= (r_state == S_SCAN) ? r_cyc + CW'(1) : '0;
            r_idle     <= (r_state == S_CAPTURE && !wr_en) ?
                          r_idle + IW'(1) : '0;
            if (w_enter_scan) begin
                r_ch   <= trig_ch;
                r_edge <= trig_edge;
            end
            if (wr_en) begin
                r_cnt <= (r_state == S_CAPTURE && r_cnt > w_wr_cnt) ?
                         r_cnt : w_wr_cnt;
            end
            if (w_abort) begin
                r_trig_found <= 1'b0;
                r_trig_addr  <= '0;
            end else if (r_state == S_SCAN && w_match) begin
                r_trig_found <= 1'b1;
                r_trig_addr  <= ADDR_W'(r_cyc - CW'(1));
            end
        end
    end

    // Read pipeline; a write in READY kills anything still in flight.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_rd_v1  <= 1'b0;
            r_rd_v2  <= 1'b0;
            r_rd_sum <= '0;
            r_rd_oob <= 1'b0;
        end else begin
            r_rd_v1  <= rd_en && (r_state == S_READY) && !wr_en;
            r_rd_sum <= {1'b0, r_trig_addr} + {1'b0, rd_offset};
            r_rd_v2  <= r_rd_v1 && !wr_en;
            r_rd_oob <= (r_rd_sum >= r_cnt);
        end
    end

    assign w_ram_raddr = (r_state == S_SCAN) ? r_cyc[ADDR_W-1:0] :
                                               r_rd_sum[ADDR_W-1:0];

    la_sample_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (clk_50M),
        .i_we    (wr_en),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_q)
    );

    assign cap_done   = r_cap_done;
    assign scan_busy  = (r_state == S_SCAN);
    assign ready      = (r_state == S_READY);
    assign trig_found = r_trig_found;
    assign trig_addr  = r_trig_addr;
    assign sample_cnt = r_cnt;
    assign rd_valid   = r_rd_v2;
    assign rd_oob     = r_rd_v2 && r_rd_oob;
    assign rd_data    = (r_rd_v2 && !r_rd_oob) ? w_ram_q : 8'h00;

endmodule
